// File: rtl/boreal_pet_sequencer.sv
// Watchdog kick controller: gathers per-core heartbeats over a fixed window and pets the watchdog over AXI4-Lite.
// Optional force-safe write on a missed check-in is enabled by defining BOREAL_PETSEQ_FORCE_SAFE_EN.
module boreal_pet_sequencer #(
  parameter int          N_CORES     = 2,
  parameter int          PET_PERIOD  = 8,
  parameter logic [31:0] WD_BASE     = 32'h0000_0000,
  parameter logic [31:0] PET_MAGIC   = 32'h1CEB_00DA,
  parameter int          AXI_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               fault_clr,
  input  logic [N_CORES-1:0] hb,
  output logic [31:0]        m_axi_awaddr,
  output logic               m_axi_awvalid,
  input  logic               m_axi_awready,
  output logic [31:0]        m_axi_wdata,
  output logic [3:0]         m_axi_wstrb,
  output logic               m_axi_wvalid,
  input  logic               m_axi_wready,
  input  logic [1:0]         m_axi_bresp,
  input  logic               m_axi_bvalid,
  output logic               m_axi_bready,
  output logic               fault,
  output logic [N_CORES-1:0] missed_mask,
  output logic [15:0]        pet_count,
  output logic               busy
);

  localparam int                 CNT_W    = $clog2(PET_PERIOD);
  localparam int                 TMO_W    = $clog2(AXI_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(PET_PERIOD - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(AXI_TIMEOUT - 1);
  localparam logic [N_CORES-1:0] ALL_IN   = {N_CORES{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WINDOW = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_RESP   = 3'd3,
    ST_FAULT  = 3'd4
  } state_t;

  state_t             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [N_CORES-1:0] mask_r;
  logic               is_pet_r;
  logic               aw_done_r;
  logic               w_done_r;
  logic [TMO_W-1:0]   tmo_r;

  logic [N_CORES-1:0] snap_s;
  logic               all_in_s;
  logic               window_end_s;
  logic               aw_ok_s;
  logic               w_ok_s;
  logic               b_hs_s;
  logic               tmo_hit_s;
  logic [15:0]        pet_next_s;

  assign m_axi_wstrb = 4'hF;

  // Heartbeat snapshot, handshake completion and timeout decode
  always_comb begin
    snap_s       = mask_r | hb;
    all_in_s     = (snap_s == ALL_IN);
    window_end_s = (cnt_r == CNT_LAST);
    aw_ok_s      = aw_done_r | (m_axi_awvalid & m_axi_awready);
    w_ok_s       = w_done_r | (m_axi_wvalid & m_axi_wready);
    b_hs_s       = m_axi_bvalid & m_axi_bready;
    tmo_hit_s    = (tmo_r >= TMO_LAST);
    if (pet_count == 16'hFFFF) begin
      pet_next_s = pet_count;
    end else begin
      pet_next_s = pet_count + 16'd1;
    end
  end

  // Sequencer FSM with registered AXI and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      cnt_r         <= '0;
      mask_r        <= '0;
      is_pet_r      <= 1'b0;
      aw_done_r     <= 1'b0;
      w_done_r      <= 1'b0;
      tmo_r         <= '0;
      m_axi_awaddr  <= 32'h0000_0000;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= 32'h0000_0000;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      fault         <= 1'b0;
      missed_mask   <= '0;
      pet_count     <= 16'd0;
      busy          <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (enable) begin
            state_r <= ST_WINDOW;
            cnt_r   <= '0;
            mask_r  <= '0;
          end
        end

        ST_WINDOW: begin
          if (!enable) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            mask_r  <= '0;
          end else if (window_end_s) begin
            cnt_r  <= '0;
            mask_r <= '0;
            if (all_in_s) begin
              state_r       <= ST_ISSUE;
              is_pet_r      <= 1'b1;
              m_axi_awaddr  <= WD_BASE + 32'h0000_0004;
              m_axi_wdata   <= PET_MAGIC;
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              aw_done_r     <= 1'b0;
              w_done_r      <= 1'b0;
              tmo_r         <= '0;
              busy          <= 1'b1;
            end else begin
              fault       <= 1'b1;
              missed_mask <= ~snap_s;
`ifdef BOREAL_PETSEQ_FORCE_SAFE_EN
              state_r       <= ST_ISSUE;
              is_pet_r      <= 1'b0;
              m_axi_awaddr  <= WD_BASE + 32'h0000_0008;
              m_axi_wdata   <= 32'h0000_0001;
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              aw_done_r     <= 1'b0;
              w_done_r      <= 1'b0;
              tmo_r         <= '0;
              busy          <= 1'b1;
`else
              state_r <= ST_FAULT;
`endif
            end
          end else begin
            cnt_r  <= cnt_r + CNT_W'(1);
            mask_r <= snap_s;
          end
        end

        ST_ISSUE: begin
          // Heartbeats arriving during the bus transaction count toward the next window
          mask_r <= snap_s;
          if (aw_ok_s && w_ok_s) begin
            state_r       <= ST_RESP;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b1;
            aw_done_r     <= 1'b0;
            w_done_r      <= 1'b0;
            tmo_r         <= tmo_r + TMO_W'(1);
          end else if (tmo_hit_s) begin
            state_r       <= ST_FAULT;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            aw_done_r     <= 1'b0;
            w_done_r      <= 1'b0;
            fault         <= 1'b1;
            busy          <= 1'b0;
          end else begin
            if (aw_ok_s) begin
              m_axi_awvalid <= 1'b0;
              aw_done_r     <= 1'b1;
            end
            if (w_ok_s) begin
              m_axi_wvalid <= 1'b0;
              w_done_r     <= 1'b1;
            end
            tmo_r <= tmo_r + TMO_W'(1);
          end
        end

        ST_RESP: begin
          mask_r <= snap_s;
          if (b_hs_s) begin
            m_axi_bready <= 1'b0;
            busy         <= 1'b0;
            if (m_axi_bresp != 2'b00) begin
              fault   <= 1'b1;
              state_r <= ST_FAULT;
            end else if (is_pet_r) begin
              pet_count <= pet_next_s;
              cnt_r     <= '0;
              state_r   <= enable ? ST_WINDOW : ST_IDLE;
            end else begin
              state_r <= ST_FAULT;
            end
          end else if (tmo_hit_s) begin
            state_r      <= ST_FAULT;
            m_axi_bready <= 1'b0;
            fault        <= 1'b1;
            busy         <= 1'b0;
          end else begin
            tmo_r <= tmo_r + TMO_W'(1);
          end
        end

        ST_FAULT: begin
          if (fault_clr) begin
            state_r     <= ST_WINDOW;
            cnt_r       <= '0;
            mask_r      <= '0;
            fault       <= 1'b0;
            missed_mask <= '0;
          end
        end

        default: begin
          state_r       <= ST_IDLE;
          m_axi_awvalid <= 1'b0;
          m_axi_wvalid  <= 1'b0;
          m_axi_bready  <= 1'b0;
          busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_boreal_pet_sequencer.sv
// Directed bench for boreal_pet_sequencer with a small configurable AXI-Lite slave responder.
module tb_boreal_pet_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        fault_clr;
  logic [1:0]  hb;
  logic [31:0] m_axi_awaddr;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wvalid;
  logic        m_axi_wready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid;
  logic        m_axi_bready;
  logic        fault;
  logic [1:0]  missed_mask;
  logic [15:0] pet_count;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Slave knobs and write log
  int          aw_stall = 0;
  int          b_mode   = 0;  // 0 OKAY, 1 SLVERR, 2 never respond
  int          aw_wait  = 0;
  logic        aw_seen  = 1'b0;
  logic        w_seen   = 1'b0;
  logic        b_pending = 1'b0;
  int          wr_count = 0;
  logic [31:0] last_awaddr = 32'h0;
  logic [31:0] last_wdata  = 32'h0;

`ifdef BOREAL_PETSEQ_FORCE_SAFE_EN
  localparam int SAFE_WR = 1;
`else
  localparam int SAFE_WR = 0;
`endif

  always #5 clk = ~clk;

  boreal_pet_sequencer #(
    .N_CORES(2), .PET_PERIOD(8), .WD_BASE(32'h0000_0000),
    .PET_MAGIC(32'h1CEB_00DA), .AXI_TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .fault_clr(fault_clr), .hb(hb),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .fault(fault), .missed_mask(missed_mask),
    .pet_count(pet_count), .busy(busy)
  );

  // Slave ready/response drive, updated on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      m_axi_awready = 1'b0;
      m_axi_wready  = 1'b0;
      m_axi_bvalid  = 1'b0;
      m_axi_bresp   = 2'b00;
      aw_wait       = 0;
    end else begin
      if (m_axi_awvalid) begin
        if (aw_wait < aw_stall) begin
          m_axi_awready = 1'b0;
          aw_wait++;
        end else begin
          m_axi_awready = 1'b1;
        end
      end else begin
        m_axi_awready = 1'b0;
        aw_wait       = 0;
      end
      m_axi_wready = m_axi_wvalid;
      if (b_pending && b_mode != 2) begin
        m_axi_bvalid = 1'b1;
        m_axi_bresp  = (b_mode == 1) ? 2'b10 : 2'b00;
      end else begin
        m_axi_bvalid = 1'b0;
        m_axi_bresp  = 2'b00;
      end
    end
  end

  // Handshake logger
  always @(posedge clk) begin
    if (rst) begin
      aw_seen   = 1'b0;
      w_seen    = 1'b0;
      b_pending = 1'b0;
    end else begin
      if (m_axi_bvalid && m_axi_bready) b_pending = 1'b0;
      if (m_axi_awvalid && m_axi_awready) begin
        last_awaddr = m_axi_awaddr;
        aw_seen     = 1'b1;
      end
      if (m_axi_wvalid && m_axi_wready) begin
        last_wdata = m_axi_wdata;
        w_seen     = 1'b1;
      end
      if (aw_seen && w_seen) begin
        aw_seen   = 1'b0;
        w_seen    = 1'b0;
        b_pending = 1'b1;
        wr_count++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One window with both cores checking in on its first cycle; ends on the issue edge
  task automatic full_window();
    hb = 2'b11;
    step(1);
    hb = 2'b00;
    step(7);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; fault_clr = 1'b0; hb = 2'b00;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    step(3);
    check("rst_awvalid", 32'(m_axi_awvalid), 32'd0);
    check("rst_wvalid",  32'(m_axi_wvalid),  32'd0);
    check("rst_bready",  32'(m_axi_bready),  32'd0);
    check("rst_awaddr",  m_axi_awaddr,       32'h0);
    check("rst_wdata",   m_axi_wdata,        32'h0);
    check("rst_wstrb",   32'(m_axi_wstrb),   32'hF);
    check("rst_fault",   32'(fault),         32'd0);
    check("rst_missed",  32'(missed_mask),   32'd0);
    check("rst_petcnt",  32'(pet_count),     32'd0);
    check("rst_busy",    32'(busy),          32'd0);
    rst = 1'b0;

    // Window 1: exact issue latency from IDLE
    enable = 1'b1;
    step(1);
    hb = 2'b11;
    step(1);
    hb = 2'b00;
    step(6);
    check("w1_no_early_valid", 32'(m_axi_awvalid), 32'd0);
    step(1);
    check("w1_awvalid", 32'(m_axi_awvalid), 32'd1);
    check("w1_wvalid",  32'(m_axi_wvalid),  32'd1);
    check("w1_awaddr",  m_axi_awaddr,       32'h0000_0004);
    check("w1_wdata",   m_axi_wdata,        32'h1CEB_00DA);
    check("w1_busy",    32'(busy),          32'd1);
    step(1);
    check("w1_valid_drop", 32'(m_axi_awvalid), 32'd0);
    check("w1_bready",     32'(m_axi_bready),  32'd1);
    step(1);
    check("w1_petcnt",   32'(pet_count), 32'd1);
    check("w1_idle_bus", 32'(busy),      32'd0);
    check("w1_log_addr", last_awaddr,    32'h0000_0004);
    check("w1_log_data", last_wdata,     32'h1CEB_00DA);

    // Window 2: heartbeat only on the final window cycle
    step(7);
    check("w2_no_early_valid", 32'(m_axi_awvalid), 32'd0);
    hb = 2'b11;
    step(1);
    hb = 2'b00;
    check("w2_last_cycle_hb", 32'(m_axi_awvalid), 32'd1);
    step(2);
    check("w2_petcnt", 32'(pet_count), 32'd2);

    // Window 3: split heartbeats accumulate
    hb = 2'b01;
    step(1);
    hb = 2'b10;
    step(1);
    hb = 2'b00;
    step(6);
    check("w3_awvalid", 32'(m_axi_awvalid), 32'd1);
    step(2);
    check("w3_petcnt",  32'(pet_count), 32'd3);
    check("w3_wrcount", 32'(wr_count),  32'd3);

    // Missed check-in: only core 0
    hb = 2'b01;
    step(1);
    hb = 2'b00;
    step(7);
    check("miss_fault",  32'(fault),         32'd1);
    check("miss_mask",   32'(missed_mask),   32'b10);
    check("miss_valid",  32'(m_axi_awvalid), 32'(SAFE_WR));
    step(3);
    check("miss_wrcount", 32'(wr_count), 32'(3 + SAFE_WR));
`ifdef BOREAL_PETSEQ_FORCE_SAFE_EN
    check("miss_safe_addr", last_awaddr, 32'h0000_0008);
    check("miss_safe_data", last_wdata,  32'h0000_0001);
`endif
    hb = 2'b11;
    step(1);
    hb = 2'b00;
    step(12);
    check("fault_no_pet",     32'(pet_count), 32'd3);
    check("fault_no_wr",      32'(wr_count),  32'(3 + SAFE_WR));
    check("fault_held",       32'(fault),     32'd1);
    fault_clr = 1'b1;
    step(1);
    fault_clr = 1'b0;
    check("clr_fault",  32'(fault),       32'd0);
    check("clr_missed", 32'(missed_mask), 32'd0);

    // Error response on a pet
    b_mode = 1;
    full_window();
    check("slverr_issue", 32'(m_axi_awvalid), 32'd1);
    step(2);
    check("slverr_fault",  32'(fault),     32'd1);
    check("slverr_petcnt", 32'(pet_count), 32'd3);
    b_mode = 0;
    fault_clr = 1'b1;
    step(1);
    fault_clr = 1'b0;
    full_window();
    step(2);
    check("recover_petcnt", 32'(pet_count), 32'd4);
    check("recover_fault",  32'(fault),     32'd0);

    // AW withheld three cycles, W immediate
    aw_stall = 3;
    full_window();
    check("stall_both_valid", 32'({m_axi_awvalid, m_axi_wvalid}), 32'b11);
    step(1);
    check("stall_wvalid_drop", 32'(m_axi_wvalid),  32'd0);
    check("stall_aw_hold1",    32'(m_axi_awvalid), 32'd1);
    step(1);
    check("stall_aw_hold2",    32'(m_axi_awvalid), 32'd1);
    step(1);
    check("stall_aw_hold3",    32'(m_axi_awvalid), 32'd1);
    check("stall_awaddr",      m_axi_awaddr,       32'h0000_0004);
    check("stall_no_bready",   32'(m_axi_bready),  32'd0);
    step(1);
    check("stall_aw_done",     32'(m_axi_awvalid), 32'd0);
    check("stall_bready",      32'(m_axi_bready),  32'd1);
    step(1);
    check("stall_petcnt",      32'(pet_count),     32'd5);
    aw_stall = 0;

    // No write response: timeout after 16 busy cycles
    b_mode = 2;
    full_window();
    step(15);
    check("tmo_not_yet", 32'(fault), 32'd0);
    check("tmo_busy",    32'(busy),  32'd1);
    step(1);
    check("tmo_fault",  32'(fault), 32'd1);
    check("tmo_valids", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_bready}), 32'd0);
    check("tmo_busy_clear", 32'(busy), 32'd0);

    // Reset in the middle of RESP
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(1);
    full_window();
    step(1);
    check("rstmid_in_resp", 32'(m_axi_bready), 32'd1);
    rst = 1'b1;
    step(1);
    check("rstmid_valids", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_bready}), 32'd0);
    check("rstmid_fault",  32'(fault),     32'd0);
    check("rstmid_petcnt", 32'(pet_count), 32'd0);
    check("rstmid_busy",   32'(busy),      32'd0);
    check("rstmid_awaddr", m_axi_awaddr,   32'h0);
    check("rstmid_wdata",  m_axi_wdata,    32'h0);
    rst = 1'b0;
    enable = 1'b0;
    b_mode = 0;
    step(3);
    check("rstmid_idle", 32'(busy), 32'd0);
    enable = 1'b1;
    step(1);
    hb = 2'b11;
    step(1);
    hb = 2'b00;
    step(6);
    check("restart_no_early", 32'(m_axi_awvalid), 32'd0);
    step(1);
    check("restart_issue", 32'(m_axi_awvalid), 32'd1);
    step(2);
    check("restart_petcnt", 32'(pet_count), 32'd1);

    // enable dropped during a transaction: completes, then idles
    full_window();
    enable = 1'b0;
    step(2);
    check("endrop_petcnt", 32'(pet_count), 32'd2);
    check("endrop_busy",   32'(busy),      32'd0);
    hb = 2'b11;
    step(12);
    hb = 2'b00;
    check("endrop_idle_valid",  32'(m_axi_awvalid), 32'd0);
    check("endrop_idle_petcnt", 32'(pet_count),     32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/boreal_pet_sequencer.md
# boreal_pet_sequencer

Watchdog kick controller: collects per-core heartbeat pulses over a fixed window. When every core has checked in, it issues the watchdog pet write (offset 0x04, magic 0x1CEB00DA) as an AXI4-Lite write master. When any core misses the window, it latches a fault and, when configured, writes force-safe (offset 0x08, bit0=1) so the actuator outputs drop to brake. It sits between the firmware cores and the watchdog's AXI-Lite slave port, and is the only writer of those two registers.

## Interface
- N_CORES, 2, number of heartbeat requesters (1..8)
- PET_PERIOD, 8, window length in cycles (≥4); must be below the watchdog timeout
- WD_BASE, 32'h0000_0000, watchdog base address
- PET_MAGIC, 32'h1CEB_00DA, pet data word
- AXI_TIMEOUT, 16, max cycles from issue to bvalid
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- enable  in  1  run sequencer
- fault_clr  in  1  pulse, clears fault (FAULT state only)
- hb  in  N_CORES  heartbeat pulses, one bit per core
- m_axi_awaddr  out  32  write address
- m_axi_awvalid  out  1  address valid
- m_axi_awready  in  1  address ready
- m_axi_wdata  out  32  write data
- m_axi_wstrb  out  4  always 4'hF
- m_axi_wvalid  out  1  data valid
- m_axi_wready  in  1  data ready
- m_axi_bresp  in  2  write response
- m_axi_bvalid  in  1  response valid
- m_axi_bready  out  1  response ready
- fault  out  1  latched check-in or bus fault
- missed_mask  out  N_CORES  cores absent in the failing window
- pet_count  out  16  successful pets, saturating
- busy  out  1  AXI transaction in flight

## Operation
- All outputs reset to 0 (awaddr/wdata 0, wstrb 4'hF). State resets to IDLE; window counter and mask reset to 0.
- States:
  - IDLE: enable=1 → WINDOW with cnt=0 and mask=0.
  - WINDOW: cnt increments each cycle; mask |= hb. At cnt==PET_PERIOD-1:
    - snap = mask|hb.
    - snap all-ones → ISSUE(pet): awaddr=WD_BASE+4, wdata=PET_MAGIC.
    - Otherwise → missed_mask=~snap and fault=1, then ISSUE(safe) if configured, else FAULT.
    - The mask clears on the same edge.
    - enable=0 in WINDOW → IDLE, mask cleared.
  - ISSUE: awvalid and wvalid assert together. Each drops independently on its own ready. When both are accepted → RESP.
  - RESP: bready=1. On bvalid:
    - bresp==OKAY and pet → pet_count+1 (saturate at 0xFFFF), then WINDOW with cnt=0.
    - bresp!=OKAY → fault=1, then FAULT.
    - Force-safe completion → FAULT.
  - ISSUE or RESP exceeding AXI_TIMEOUT cycles (counted from entry into ISSUE) → fault=1, all valids dropped, then FAULT.
  - FAULT: petting stops. fault_clr → WINDOW with cnt=0, mask=0, fault=0, missed_mask=0. fault_clr outside FAULT is ignored.
- hb during ISSUE/RESP accumulates into the next window's mask.
- enable=0 during ISSUE/RESP does not abort; the transaction completes first, then → IDLE.
- busy=1 in ISSUE and RESP.

## Timing
- AW/W valid rises one cycle after the cnt==PET_PERIOD-1 edge.
- Ready-high-at-assert slave: valid for 1 cycle, bready on the next cycle. Minimum pet cycle is PET_PERIOD+2 cycles plus slave B latency.
- Valids are held stable, with address and data unchanged, until accepted (AXI rule).
- A hb pulse on the final window cycle counts for that window.
- rst mid-transaction abandons the bus immediately (valids 0 the next cycle). The slave must be reset with it.
- The fault set and missed_mask update on the same edge.

## Configuration
- BOREAL_PETSEQ_FORCE_SAFE_EN defined: a missed check-in issues a force-safe write (WD_BASE+8, data 32'h1) before entering FAULT.
- Undefined: a missed check-in goes straight to FAULT with no bus write; the watchdog then times out on its own.

## Test plan
- N_CORES=2, PET_PERIOD=8. Both hb pulsed each window with an always-ready slave → one write per window: awaddr=0x04, wdata=0x1CEB00DA; pet_count reaches 3 after 3 windows.
- hb[0] only in the window → fault=1, missed_mask=2'b10. With the macro, one write to 0x08 with data 1. Without it, no write. No further pets.
- Slave withholds awready 3 cycles while wready is immediate → wvalid drops after 1 cycle; awvalid and awaddr hold stable 3 cycles; then bready asserts.
- Slave returns bresp=2'b10 on a pet → fault=1, pet_count unchanged. fault_clr, then both hb → the next pet succeeds.
- Slave never asserts bvalid → fault=1 after 16 cycles, valids 0.
- rst asserted mid-RESP → all outputs 0 the next cycle, state IDLE.
